ibex_pext_mult_seq: RTL and testbench
=====================================

IBEX_PEXT_MULT_SEQ -- requirements
Module: ibex_pext_mult_seq

Interface
REQ-001 SHALL have parameter MultLatency, default 1, giving cycles per multiplier pass; legal range 1..3.
REQ-002 SHALL have port clk_i, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port req_valid_i, input, 1, mult op offered by the decode stage (zpn_mult_sel asserted).
REQ-005 SHALL have port req_ready_o, output, 1, sequencer can accept a request.
REQ-006 SHALL have port mult_class_i, input, 2, operand class:
  - 00 = 8x8
  - 01 = 16x16
  - 10 = 32x16
  - 11 = 32x32
REQ-007 SHALL have port accum_i, input, 1, op accumulates into rd (KMADA, KMMAC, SMAQA, MADDR32 class).
REQ-008 SHALL have port kill_i, input, 1, pipeline flush; abandons the current op.
REQ-009 SHALL have port mult_en_o, output, 1, enables the shared 16x16 multiplier array.
REQ-010 SHALL have port pass_idx_o, output, 2, selects the operand half-word pair for the current pass.
REQ-011 SHALL have port acc_clr_o, output, 1, clears the partial-product accumulator.
REQ-012 SHALL have port acc_en_o, output, 1, latches the multiplier output into the accumulator.
REQ-013 SHALL have port add_rd_o, output, 1, adds rd into the accumulator (saturating, done in the datapath).
REQ-014 SHALL have port res_valid_o, output, 1, result available.
REQ-015 SHALL have port res_ready_i, input, 1, result consumed.
REQ-016 SHALL have port busy_o, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, MULT, ACCUM, DONE.
REQ-018 SHALL drive req_ready_o high only in IDLE with kill_i low; a request is accepted on a cycle where req_valid_i and req_ready_o are both high.
REQ-019 SHALL, on accept, register mult_class_i and accum_i, clear the pass counter and the cycle counter, and enter MULT on the next cycle.
REQ-020 SHALL set the pass count by class: 00 -> 1, 01 -> 1, 10 -> 2, 11 -> 4.
REQ-021 SHALL, in MULT, assert mult_en_o every cycle and drive pass_idx_o with the pass counter.
REQ-022 SHALL hold each pass for MultLatency cycles, counted by a cycle counter that wraps to 0 at the end of each pass.
REQ-023 SHALL assert acc_en_o only on the last cycle of each pass.
REQ-024 SHALL assert acc_clr_o together with acc_en_o on pass 0 only, so the datapath loads the product rather than adding it.
REQ-025 SHALL, on the last cycle of the last pass, go to ACCUM if the registered accum is 1, else to DONE.
REQ-026 SHALL hold ACCUM for exactly 1 cycle with add_rd_o high, then go to DONE.
REQ-027 SHALL, in DONE, hold res_valid_o high until res_ready_i is high, then return to IDLE on the next cycle; no new request is accepted in that same cycle.
REQ-028 SHALL give kill_i priority over all transitions: any state goes to IDLE next cycle, res_valid_o is never asserted for the killed op, and a request offered in the same cycle is not accepted.
REQ-029 SHALL drive all datapath strobes (mult_en_o, acc_clr_o, acc_en_o, add_rd_o) low outside MULT and ACCUM, and drive pass_idx_o to 0 outside MULT.
REQ-030 SHALL, with MultLatency=1 and accum=0, make res_valid_o rise N+1 cycles after the accept edge, where N is the pass count; accum=1 adds 1 cycle.
REQ-031 SHALL ignore mult_class_i and accum_i changes after accept.

Reset
REQ-032 SHALL, while rst_i is high at a clock edge, force state IDLE and both counters to 0.
REQ-033 SHALL, after reset, hold res_valid_o, busy_o and all strobes low, and req_ready_o high, starting the next cycle.
REQ-034 SHALL treat reset asserted mid-operation like kill_i: no result is produced and the op is lost.

Configuration
REQ-035 SHALL, with macro IBEX_PEXT_MULT_FAST_EN defined, target a 32x16-wide multiplier:
  - class 10 takes 1 pass
  - class 11 takes 2 passes, pass_idx_o 0 then 1
  - classes 00 and 01 are unchanged
REQ-036 SHALL, without IBEX_PEXT_MULT_FAST_EN, use the pass counts of REQ-020.

Verification
REQ-037 SHALL cover: MultLatency=1, class 11, accum=0, res_ready_i tied high -> pass_idx_o 0,1,2,3 on cycles 1-4, acc_clr_o on cycle 1 only, res_valid_o on cycle 5, req_ready_o back high on cycle 6.
REQ-038 SHALL cover: MultLatency=2, class 10, accum=1 -> pass 0 on cycles 1-2 with acc_en_o on cycle 2, pass 1 on cycles 3-4 with acc_en_o on cycle 4, add_rd_o on cycle 5, res_valid_o on cycle 6.
REQ-039 SHALL cover: class 01 op, res_ready_i low for 3 cycles in DONE -> res_valid_o held for 4 cycles, busy_o high throughout, req_valid_i ignored.
REQ-040 SHALL cover: kill_i pulsed on cycle 2 of a class 11 op -> IDLE on cycle 3, no res_valid_o; kill_i plus req_valid_i in IDLE -> no accept.
REQ-041 SHALL cover: rst_i asserted on cycle 3 of an accum op -> all outputs at reset values on the next cycle, no add_rd_o.
REQ-042 SHALL cover: IBEX_PEXT_MULT_FAST_EN defined, class 11, MultLatency=1 -> passes on cycles 1-2, res_valid_o on cycle 3.

Source files
------------

// File: rtl/ibex_pext_mult_seq.sv
// ibex_pext_mult_seq: control sequencer for the P-extension multi-pass multiplier.
// It steps a shared 16x16 multiplier array through 1..4 operand passes, each
// MultLatency cycles long. It optionally adds rd for one cycle, then holds the
// result until it is consumed.
// Optional build macro IBEX_PEXT_MULT_FAST_EN targets a 32x16 array. With it,
// class 10 needs one pass and class 11 needs two passes.
module ibex_pext_mult_seq #(
    parameter int unsigned MultLatency = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [1:0] mult_class_i,
    input  logic       accum_i,
    input  logic       kill_i,
    output logic       mult_en_o,
    output logic [1:0] pass_idx_o,
    output logic       acc_clr_o,
    output logic       acc_en_o,
    output logic       add_rd_o,
    output logic       res_valid_o,
    input  logic       res_ready_i,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] LAT_LAST = 2'(MultLatency - 1);

    state_e     state_q, state_d;
    logic [1:0] pass_q, pass_d;
    logic [1:0] cyc_q, cyc_d;
    logic [1:0] class_q, class_d;
    logic       accum_q, accum_d;

    // Index of the final pass for a given operand class.
    function automatic logic [1:0] last_pass(input logic [1:0] cls);
`ifdef IBEX_PEXT_MULT_FAST_EN
        case (cls)
            2'b11:   last_pass = 2'd1;
            default: last_pass = 2'd0;
        endcase
`else
        case (cls)
            2'b10:   last_pass = 2'd1;
            2'b11:   last_pass = 2'd3;
            default: last_pass = 2'd0;
        endcase
`endif
    endfunction

    // State, counters and captured op attributes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pass_q  <= 2'd0;
            cyc_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            cyc_q   <= cyc_d;
        end
        class_q <= class_d;
        accum_q <= accum_d;
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        cyc_d       = cyc_q;
        class_d     = class_q;
        accum_d     = accum_q;
        req_ready_o = 1'b0;
        mult_en_o   = 1'b0;
        pass_idx_o  = 2'd0;
        acc_clr_o   = 1'b0;
        acc_en_o    = 1'b0;
        add_rd_o    = 1'b0;
        res_valid_o = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = ~kill_i;
                if (req_valid_i && !kill_i) begin
                    class_d = mult_class_i;
                    accum_d = accum_i;
                    pass_d  = 2'd0;
                    cyc_d   = 2'd0;
                    state_d = MULT;
                end
            end
            MULT: begin
                mult_en_o  = 1'b1;
                pass_idx_o = pass_q;
                if (cyc_q == LAT_LAST) begin
                    // Product is ready: pass 0 loads it, later passes add to it.
                    acc_en_o  = 1'b1;
                    acc_clr_o = (pass_q == 2'd0);
                    cyc_d     = 2'd0;
                    if (pass_q == last_pass(class_q)) begin
                        pass_d  = 2'd0;
                        state_d = accum_q ? ACCUM : DONE;
                    end else begin
                        pass_d = pass_q + 2'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 2'd1;
                end
            end
            ACCUM: begin
                add_rd_o = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                // A kill landing in the first DONE cycle still suppresses the result.
                res_valid_o = ~kill_i;
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (kill_i) begin
            state_d = IDLE;
            pass_d  = 2'd0;
            cyc_d   = 2'd0;
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_pext_mult_seq.sv
// Bench for ibex_pext_mult_seq: two instances, MultLatency 1 and 2, share the stimulus.
// The table vectors check the per-cycle strobe timeline of both instances.
// Hand-written sequences cover result back-pressure, kill and mid-op reset.
module tb_ibex_pext_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, req_valid, accum, kill, res_ready;
    logic [1:0] mult_class;

    logic       rdy1, men1, clr1, aen1, add1, val1, busy1;
    logic [1:0] pidx1;
    logic       rdy2, men2, clr2, aen2, add2, val2, busy2;
    logic [1:0] pidx2;

    ibex_pext_mult_seq #(.MultLatency(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy1),
        .mult_class_i(mult_class), .accum_i(accum), .kill_i(kill),
        .mult_en_o(men1), .pass_idx_o(pidx1), .acc_clr_o(clr1), .acc_en_o(aen1),
        .add_rd_o(add1), .res_valid_o(val1), .res_ready_i(res_ready), .busy_o(busy1)
    );

    ibex_pext_mult_seq #(.MultLatency(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy2),
        .mult_class_i(mult_class), .accum_i(accum), .kill_i(kill),
        .mult_en_o(men2), .pass_idx_o(pidx2), .acc_clr_o(clr2), .acc_en_o(aen2),
        .add_rd_o(add2), .res_valid_o(val2), .res_ready_i(res_ready), .busy_o(busy2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0] cls;
        logic       acc;
        int         npass;
        int         vcyc1;   // cycle of res_valid_o for MultLatency=1
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected timeline for an op of n passes at latency lat, cycle c after accept.
    task automatic chk_cycle(input string tag, input int c, input int lat, input int n,
                             input int acc, input int vcyc,
                             input logic men, input logic [1:0] pidx, input logic clr,
                             input logic aen, input logic add, input logic val,
                             input logic busy, input logic rdy);
        int  mt;
        bit  in_mult, last;
        int  ep;
        mt      = lat * n;
        in_mult = (c >= 1) && (c <= mt);
        ep      = in_mult ? (c - 1) / lat : 0;
        last    = in_mult && ((c % lat) == 0);
        chk($sformatf("%s c%0d mult_en", tag, c), int'(men), int'(in_mult));
        chk($sformatf("%s c%0d pass_idx", tag, c), int'(pidx), ep);
        chk($sformatf("%s c%0d acc_en", tag, c), int'(aen), int'(last));
        chk($sformatf("%s c%0d acc_clr", tag, c), int'(clr), int'(last && ep == 0));
        chk($sformatf("%s c%0d add_rd", tag, c), int'(add), int'(acc != 0 && c == mt + 1));
        chk($sformatf("%s c%0d res_valid", tag, c), int'(val), int'(c == vcyc));
        chk($sformatf("%s c%0d busy", tag, c), int'(busy), int'(c >= 1 && c <= vcyc));
        chk($sformatf("%s c%0d req_ready", tag, c), int'(rdy), int'(!(c >= 1 && c <= vcyc)));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " dut1 req_ready"}, int'(rdy1), 1);
        chk({tag, " dut1 busy"}, int'(busy1), 0);
        chk({tag, " dut1 strobes"}, int'({men1, clr1, aen1, add1, val1, pidx1}), 0);
        chk({tag, " dut2 req_ready"}, int'(rdy2), 1);
        chk({tag, " dut2 busy"}, int'(busy2), 0);
        chk({tag, " dut2 strobes"}, int'({men2, clr2, aen2, add2, val2, pidx2}), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle("reset");
    endtask

    // Offer an op, take the accept edge, then scramble the op inputs.
    task automatic accept(input logic [1:0] cls, input logic acc);
        @(negedge clk);
        req_valid  = 1'b1;
        mult_class = cls;
        accum      = acc;
        #1;
        chk("accept dut1 req_ready", int'(rdy1), 1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        mult_class = ~cls;
        accum      = ~acc;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; accum = 1'b0; kill = 1'b0;
        res_ready = 1'b1; mult_class = 2'b00;

`ifdef IBEX_PEXT_MULT_FAST_EN
        vecs[0] = '{2'b00, 1'b0, 1, 2};
        vecs[1] = '{2'b01, 1'b0, 1, 2};
        vecs[2] = '{2'b10, 1'b0, 1, 2};
        vecs[3] = '{2'b11, 1'b0, 2, 3};
        vecs[4] = '{2'b00, 1'b1, 1, 3};
        vecs[5] = '{2'b11, 1'b1, 2, 4};
        vecs[6] = '{2'b10, 1'b1, 1, 3};
`else
        vecs[0] = '{2'b00, 1'b0, 1, 2};
        vecs[1] = '{2'b01, 1'b0, 1, 2};
        vecs[2] = '{2'b10, 1'b0, 2, 3};
        vecs[3] = '{2'b11, 1'b0, 4, 5};
        vecs[4] = '{2'b00, 1'b1, 1, 3};
        vecs[5] = '{2'b11, 1'b1, 4, 6};
        vecs[6] = '{2'b10, 1'b1, 2, 4};
`endif

        // Table-driven ops, res_ready_i held high.
        for (int v = 0; v < 7; v++) begin
            int acc_i;
            int vcyc2;
            acc_i = int'(vecs[v].acc);
            vcyc2 = 2 * vecs[v].npass + 1 + acc_i;
            do_reset();
            accept(vecs[v].cls, vecs[v].acc);
            for (int c = 1; c <= vcyc2 + 1; c++) begin
                @(negedge clk);
                chk_cycle($sformatf("v%0d L1", v), c, 1, vecs[v].npass, acc_i, vecs[v].vcyc1,
                          men1, pidx1, clr1, aen1, add1, val1, busy1, rdy1);
                chk_cycle($sformatf("v%0d L2", v), c, 2, vecs[v].npass, acc_i, vcyc2,
                          men2, pidx2, clr2, aen2, add2, val2, busy2, rdy2);
            end
        end

        // Class 01 with result back-pressure; req_valid offered while waiting.
        do_reset();
        accept(2'b01, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            res_ready = (c >= 5);
            req_valid = (c >= 2 && c <= 5);
            #1;
            chk($sformatf("bp c%0d res_valid", c), int'(val1), int'(c >= 2 && c <= 5));
            chk($sformatf("bp c%0d busy", c), int'(busy1), int'(c <= 5));
            if (c >= 2 && c <= 5) chk($sformatf("bp c%0d req_ready", c), int'(rdy1), 0);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;

        // Kill on cycle 2 of a class 11 op.
        do_reset();
        accept(2'b11, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            kill = (c == 2);
            #1;
            if (c == 2) chk("kill c2 req_ready", int'(rdy1), 0);
            if (c >= 3) begin
                chk($sformatf("kill c%0d busy1", c), int'(busy1), 0);
                chk($sformatf("kill c%0d busy2", c), int'(busy2), 0);
                chk($sformatf("kill c%0d res_valid1", c), int'(val1), 0);
                chk($sformatf("kill c%0d res_valid2", c), int'(val2), 0);
                chk($sformatf("kill c%0d mult_en1", c), int'(men1), 0);
            end
        end
        // Kill together with a request in IDLE: no accept.
        @(negedge clk);
        kill = 1'b1;
        req_valid = 1'b1;
        mult_class = 2'b11;
        #1;
        chk("kill+req req_ready", int'(rdy1), 0);
        @(negedge clk);
        kill = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("kill+req busy1", int'(busy1), 0);
        chk("kill+req busy2", int'(busy2), 0);

        // Reset on cycle 3 of an accumulating class 11 op.
        do_reset();
        accept(2'b11, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            rst = (c == 3);
            #1;
            if (c == 4) chk_idle("rst mid-op");
            if (c >= 4) begin
                chk($sformatf("rst c%0d add_rd1", c), int'(add1), 0);
                chk($sformatf("rst c%0d add_rd2", c), int'(add2), 0);
                chk($sformatf("rst c%0d res_valid1", c), int'(val1), 0);
                chk($sformatf("rst c%0d res_valid2", c), int'(val2), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
